// File: rtl/glitch_filter_if.sv
// -----------------------------------------------------------------------------
// glitch_filter_if
//   Bundles the control, data and monitor signals of the glitch filter so that
//   the filter and whatever drives it share one typed connection.
//
//   Signals:
//     en           - filter enable; 0 freezes filter state, dout, flags, counter
//     bypass       - 1: dout follows the synchronised input, no glitch detection
//     clr          - synchronous clear of glitch_flag and glitch_cnt
//     din          - raw, possibly hazardous, channel inputs
//     dout         - filtered outputs (registered)
//     glitch_pulse - one-cycle strobe per channel when a glitch is rejected
//     glitch_flag  - sticky per-channel glitch seen
//     glitch_cnt   - saturating count of rejected glitches over all channels
//
//   Modports:
//     master - the side that drives en/bypass/clr/din and observes the results
//     slave  - the filter itself
// -----------------------------------------------------------------------------
interface glitch_filter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);

  logic             en;
  logic             bypass;
  logic             clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] glitch_pulse;
  logic [WIDTH-1:0] glitch_flag;
  logic [CNT_W-1:0] glitch_cnt;

  modport master (
    output en, bypass, clr, din,
    input  dout, glitch_pulse, glitch_flag, glitch_cnt
  );

  modport slave (
    input  en, bypass, clr, din,
    output dout, glitch_pulse, glitch_flag, glitch_cnt
  );

endinterface

// File: rtl/glitch_filter.sv
// -----------------------------------------------------------------------------
// glitch_filter
//   Multi-channel glitch (static hazard) filter and monitor. Each channel is
//   passed through a two-flop synchroniser; the filtered output only follows a
//   change once the synchronised input has held the new value for
//   STABLE_CYCLES consecutive clocks. Shorter excursions are rejected, strobed
//   on glitch_pulse, latched in glitch_flag and counted in glitch_cnt.
//
//   Parameters:
//     WIDTH         - number of independent channels
//     STABLE_CYCLES - cycles a changed input must hold before dout follows (>=1)
//     CNT_W         - width of the saturating glitch event counter
//
//   Ports:
//     clk   - rising-edge clock
//     rst_n - synchronous active-low reset
//     bus   - glitch_filter_if slave modport (en, bypass, clr, din in;
//             dout, glitch_pulse, glitch_flag, glitch_cnt out)
// -----------------------------------------------------------------------------
module glitch_filter #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  glitch_filter_if.slave  bus
);

  localparam int RUN_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

  // Run value at which one more differing cycle completes the stable window.
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [WIDTH-1:0]            sync1_q;
  logic [WIDTH-1:0]            sync_q;
  logic [WIDTH-1:0][RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0]            dout_q, dout_d;
  logic [WIDTH-1:0]            pulse_q, pulse_d;
  logic [WIDTH-1:0]            flag_q, flag_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  logic [WIDTH-1:0]            glitchVec;
  logic [31:0]                 popCnt;
  logic [31:0]                 cntSum;
  logic [CNT_W-1:0]            cntBase;

  // Next-state logic. Each channel is IDLE while run is 0 and PENDING while a
  // differing input is being timed. A return to dout while PENDING is a
  // rejected glitch. clr wipes the history but still records this cycle's
  // glitches so that no event is lost at the moment of clearing.
  always_comb begin
    run_d     = run_q;
    dout_d    = dout_q;
    flag_d    = flag_q;
    cnt_d     = cnt_q;
    glitchVec = '0;
    popCnt    = '0;
    cntSum    = '0;
    cntBase   = cnt_q;

    if (bus.en) begin
      if (bus.bypass) begin
        dout_d = sync_q;
        run_d  = '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_q[i] != dout_q[i]) begin
            if (run_q[i] == RUN_LAST) begin
              dout_d[i] = sync_q[i];
              run_d[i]  = '0;
            end else begin
              run_d[i] = run_q[i] + RUN_W'(1);
            end
          end else if (run_q[i] != '0) begin
            run_d[i]     = '0;
            glitchVec[i] = 1'b1;
          end
        end
      end

      for (int i = 0; i < WIDTH; i++) begin
        popCnt = popCnt + 32'(glitchVec[i]);
      end

      if (bus.clr) begin
        flag_d  = glitchVec;
        cntBase = '0;
      end else begin
        flag_d  = flag_q | glitchVec;
      end

      // Sum in 32 bits so a many-channel burst cannot wrap before saturation.
      cntSum = 32'(cntBase) + popCnt;
      if (cntSum > CNT_MAX) begin
        cnt_d = '1;
      end else begin
        cnt_d = cntSum[CNT_W-1:0];
      end
    end

    pulse_d = glitchVec;
  end

  // State registers. The synchroniser runs even when the filter is disabled so
  // that re-enabling sees an up-to-date input. Reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
      run_q   <= '0;
      dout_q  <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= bus.din;
      sync_q  <= sync1_q;
      run_q   <= run_d;
      dout_q  <= dout_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.glitch_pulse = pulse_q;
  assign bus.glitch_flag  = flag_q;
  assign bus.glitch_cnt   = cnt_q;

endmodule

// File: tb/tb_glitch_filter.sv
// -----------------------------------------------------------------------------
// tb_glitch_filter
//   Directed bench for glitch_filter with WIDTH=4, STABLE_CYCLES=3, CNT_W=2.
//   A per-cycle vector table covers reset, hazard rejection, boundary pulse
//   lengths, multi-channel saturation and clr; hand sequences cover bypass,
//   enable and reset in the middle of a pending change.
// -----------------------------------------------------------------------------
module tb_glitch_filter;

  localparam int WIDTH         = 4;
  localparam int STABLE_CYCLES = 3;
  localparam int CNT_W         = 2;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  glitch_filter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  glitch_filter #(
    .WIDTH(WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic             rstN;
    logic             en;
    logic             bypass;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] expDout;
    logic [WIDTH-1:0] expPulse;
    logic [WIDTH-1:0] expFlag;
    logic [CNT_W-1:0] expCnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic r, input logic e, input logic b,
                                 input logic c, input logic [WIDTH-1:0] d,
                                 input logic [WIDTH-1:0] xd,
                                 input logic [WIDTH-1:0] xp,
                                 input logic [WIDTH-1:0] xf,
                                 input logic [CNT_W-1:0] xc);
    vec_t v;
    v.rstN = r; v.en = e; v.bypass = b; v.clr = c; v.din = d;
    v.expDout = xd; v.expPulse = xp; v.expFlag = xf; v.expCnt = xc;
    vecs.push_back(v);
  endfunction

  // Drive inputs just after a rising edge, then advance to 1 unit past the
  // next rising edge so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic r, input logic e, input logic b,
                               input logic c, input logic [WIDTH-1:0] d);
    rst_n      = r;
    bus.en     = e;
    bus.bypass = b;
    bus.clr    = c;
    bus.din    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [WIDTH-1:0] xd,
                             input logic [WIDTH-1:0] xp,
                             input logic [WIDTH-1:0] xf,
                             input logic [CNT_W-1:0] xc);
    checks++;
    if (bus.dout !== xd) begin
      errors++;
      $display("[TB] FAIL %s dout got %h want %h", tag, bus.dout, xd);
    end
    checks++;
    if (bus.glitch_pulse !== xp) begin
      errors++;
      $display("[TB] FAIL %s glitch_pulse got %h want %h", tag, bus.glitch_pulse, xp);
    end
    checks++;
    if (bus.glitch_flag !== xf) begin
      errors++;
      $display("[TB] FAIL %s glitch_flag got %h want %h", tag, bus.glitch_flag, xf);
    end
    checks++;
    if (bus.glitch_cnt !== xc) begin
      errors++;
      $display("[TB] FAIL %s glitch_cnt got %0d want %0d", tag, bus.glitch_cnt, xc);
    end
  endtask

  // Safety net in case the stimulus never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset held 3 clocks with all inputs high.
    for (int i = 0; i < 3; i++) addVec(0, 1, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 2'd0);
    // Release: dout rises on the 5th edge after release.
    for (int i = 0; i < 4; i++) addVec(1, 1, 0, 0, 4'hF, 4'h0, 4'h0, 4'h0, 2'd0);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 2'd0);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 2'd0);
    // Static-1 hazard on channel 0, 1 clock low.
    addVec(1, 1, 0, 0, 4'hE, 4'hF, 4'h0, 4'h0, 2'd0);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 2'd0);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h0, 2'd0);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h1, 4'h1, 2'd1);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h1, 2'd1);
    // Channel 1, 2-clock low pulse: rejected.
    addVec(1, 1, 0, 0, 4'hD, 4'hF, 4'h0, 4'h1, 2'd1);
    addVec(1, 1, 0, 0, 4'hD, 4'hF, 4'h0, 4'h1, 2'd1);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h1, 2'd1);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h1, 2'd1);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h2, 4'h3, 2'd2);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h3, 2'd2);
    // Channel 1, 3-clock low pulse: accepted, then accepted back high.
    for (int i = 0; i < 3; i++) addVec(1, 1, 0, 0, 4'hD, 4'hF, 4'h0, 4'h3, 2'd2);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h3, 2'd2);
    for (int i = 0; i < 3; i++) addVec(1, 1, 0, 0, 4'hF, 4'hD, 4'h0, 4'h3, 2'd2);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h3, 2'd2);
    // All four channels glitch together: counter saturates at 3.
    addVec(1, 1, 0, 0, 4'h0, 4'hF, 4'h0, 4'h3, 2'd2);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h3, 2'd2);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h3, 2'd2);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF, 2'd3);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'hF, 2'd3);
    // A further glitch on channel 0 keeps the counter saturated.
    addVec(1, 1, 0, 0, 4'hE, 4'hF, 4'h0, 4'hF, 2'd3);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'hF, 2'd3);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'hF, 2'd3);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h1, 4'hF, 2'd3);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'hF, 2'd3);
    // clr coincident with a glitch on channel 2.
    addVec(1, 1, 0, 0, 4'hB, 4'hF, 4'h0, 4'hF, 2'd3);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'hF, 2'd3);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'hF, 2'd3);
    addVec(1, 1, 0, 1, 4'hF, 4'hF, 4'h4, 4'h4, 2'd1);
    addVec(1, 1, 0, 0, 4'hF, 4'hF, 4'h0, 4'h4, 2'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].en, vecs[i].bypass, vecs[i].clr, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), vecs[i].expDout, vecs[i].expPulse,
                  vecs[i].expFlag, vecs[i].expCnt);
    end

    // Bypass: a 1-clock pulse on channel 0 reappears on dout, no glitch events.
    applyStimulus(1, 1, 1, 0, 4'hF); checkOutput("byp0", 4'hF, 4'h0, 4'h4, 2'd1);
    applyStimulus(1, 1, 1, 0, 4'hE); checkOutput("byp1", 4'hF, 4'h0, 4'h4, 2'd1);
    applyStimulus(1, 1, 1, 0, 4'hF); checkOutput("byp2", 4'hF, 4'h0, 4'h4, 2'd1);
    applyStimulus(1, 1, 1, 0, 4'hF); checkOutput("byp3", 4'hE, 4'h0, 4'h4, 2'd1);
    applyStimulus(1, 1, 1, 0, 4'hF); checkOutput("byp4", 4'hF, 4'h0, 4'h4, 2'd1);
    applyStimulus(1, 1, 0, 0, 4'hF); checkOutput("bypExit", 4'hF, 4'h0, 4'h4, 2'd1);

    // Disabled: dout frozen while the input falls.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 4'h0);
      checkOutput($sformatf("enOff%0d", i), 4'hF, 4'h0, 4'h4, 2'd1);
    end
    // Re-enabled: dout follows STABLE_CYCLES clocks later.
    applyStimulus(1, 1, 0, 0, 4'h0); checkOutput("enOn1", 4'hF, 4'h0, 4'h4, 2'd1);
    applyStimulus(1, 1, 0, 0, 4'h0); checkOutput("enOn2", 4'hF, 4'h0, 4'h4, 2'd1);
    applyStimulus(1, 1, 0, 0, 4'h0); checkOutput("enOn3", 4'h0, 4'h0, 4'h4, 2'd1);

    // Channel 3 rises and reaches run=2, then reset cuts it off.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 4'h8);
      checkOutput($sformatf("pend%0d", i), 4'h0, 4'h0, 4'h4, 2'd1);
    end
    applyStimulus(0, 1, 0, 0, 4'h8); checkOutput("midRst0", 4'h0, 4'h0, 4'h0, 2'd0);
    applyStimulus(0, 1, 0, 0, 4'h8); checkOutput("midRst1", 4'h0, 4'h0, 4'h0, 2'd0);
    // After release, same latency as from power-up.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 4'hF);
      checkOutput($sformatf("rel%0d", i), 4'h0, 4'h0, 4'h0, 2'd0);
    end
    applyStimulus(1, 1, 0, 0, 4'hF); checkOutput("rel4", 4'hF, 4'h0, 4'h0, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glitch_filter.md
Name: glitch_filter

Overview:
- Parametrised multi-channel glitch (hazard) filter and monitor.
- Sits downstream of combinational logic that can produce static hazards, such as a sum-of-products output missing its consensus term.
- Each channel is synchronised, then an output change is accepted only after the input has held its new value for STABLE_CYCLES clocks.
- Shorter pulses are rejected and counted, so hazardous transitions are both suppressed and measurable on silicon.

Parameters:
- WIDTH, 4: number of independent channels.
- STABLE_CYCLES, 3: consecutive cycles a changed input must hold before dout follows. Legal range >= 1.
- CNT_W, 8: width of the saturating glitch event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  filter enable. 0 freezes filter state, dout, flags and counter.
- bypass  input  1  1: dout follows the synchronised input and glitch detection is off.
- clr  input  1  synchronous clear of glitch_flag and glitch_cnt.
- din  input  WIDTH  raw, possibly hazardous, channel inputs.
- dout  output  WIDTH  filtered outputs (registered).
- glitch_pulse  output  WIDTH  one-cycle strobe per channel when a glitch is rejected.
- glitch_flag  output  WIDTH  sticky per-channel glitch seen.
- glitch_cnt  output  CNT_W  total rejected glitches across all channels, saturating.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - sync stages, dout, run counters, glitch_pulse, glitch_flag and glitch_cnt all go to 0.
  - Reset overrides en, bypass and clr.
- Synchroniser:
  - 2-flop synchroniser per channel: din -> s1 -> s. Runs regardless of en.
  - s is the filter input.
- Per-channel state: run counter, width clog2(STABLE_CYCLES+1).
  - Two implicit states: IDLE (run=0) and PENDING (run>0).
- Per-cycle rules, applied when en=1 and bypass=0:
  - s != dout:
    - run <= run+1.
    - If run+1 == STABLE_CYCLES: dout <= s and run <= 0 (accept).
  - s == dout and run > 0 (glitch):
    - run <= 0.
    - glitch_pulse[i] <= 1 for exactly one cycle.
    - glitch_flag[i] <= 1.
  - s == dout and run == 0: no change.
- Latency: a clean din edge reaches dout 2 + STABLE_CYCLES clocks after the first sampling edge.
- Glitch length:
  - A pulse on s lasting k < STABLE_CYCLES cycles is rejected.
  - The detection strobe occurs the cycle after s returns.
- STABLE_CYCLES=1: dout tracks s with one cycle of delay; glitches are impossible.
- glitch_cnt:
  - Each cycle, adds the popcount of channels glitching that cycle.
  - Saturates at 2^CNT_W-1 and never wraps.
- clr priority:
  - clr=1 clears glitch_flag and glitch_cnt.
  - A glitch in the same cycle is still recorded: flag set for that channel, cnt = popcount of that cycle's glitches.
  - glitch_pulse is unaffected by clr.
- en=0: run, dout, glitch_flag and glitch_cnt hold. glitch_pulse is 0.
- bypass=1:
  - dout <= s every cycle and run <= 0.
  - No glitch events; glitch_pulse is 0; flags and cnt hold unless clr.
  - Leaving bypass resumes filtering from the current dout with run=0.
- Reset mid-PENDING: run is discarded, no glitch is reported, and dout returns to 0.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 clocks with din=4'hF -> dout, glitch_pulse, glitch_flag and glitch_cnt all 0. Release -> dout=4'hF exactly 2+3=5 clocks after the first sampling edge.
- Static-1 hazard (defaults):
  - Stimulus: din[0] high and settled, then driven low for 1 clock and high again.
  - Required: dout[0] stays 1.
  - Required: glitch_pulse[0] asserts exactly one cycle, 1 clock after s[0] returns high.
  - Required: glitch_flag[0]=1, glitch_cnt=1.
- Boundary pulse lengths, din[1]:
  - 2-cycle low pulse -> rejected, cnt increments.
  - 3-cycle low pulse -> dout[1] falls after 3 cycles of low s, and no glitch is reported.
  - Returning high afterwards takes a further 3 cycles.
- Simultaneous glitches and saturation (CNT_W=2):
  - 1-cycle pulses on all 4 channels in the same cycle -> cnt=3 (saturated), glitch_flag=4'hF.
  - Further glitches keep cnt=3.
  - clr with a coincident glitch on channel 2 -> cnt=1, glitch_flag=4'b0100.
- Mode control:
  - bypass=1 with a 1-cycle pulse -> dout reproduces the pulse 2 clocks later; pulse=0, cnt unchanged.
  - en=0 while din changes -> dout frozen.
  - Re-enable -> dout updates STABLE_CYCLES clocks later.
- Reset mid-operation: assert rst_n=0 while run=2 on channel 3 -> all outputs 0 next clock and no glitch_pulse. After release, behaviour matches the reset/idle scenario.
